// File: rtl/button_event_decoder_if.sv
// Debouncer pulses in, gesture events out, for the button event decoder.
interface button_event_decoder_if;
  logic pb_down;
  logic pb_up;
  logic short_press;
  logic long_press;
  logic double_press;
  logic repeat_pulse;
  logic held;

  modport master (
    output pb_down, pb_up,
    input  short_press, long_press, double_press, repeat_pulse, held
  );

  modport slave (
    input  pb_down, pb_up,
    output short_press, long_press, double_press, repeat_pulse, held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced press/release pulses into short, long, double and
// held-repeat gestures; all outputs are registered one-cycle pulses plus held.
module button_event_decoder #(
  parameter int unsigned           CNT_W      = 24,
  parameter logic [CNT_W-1:0]      LONG_CNT   = 24'd12_000_000,
  parameter logic [CNT_W-1:0]      DBL_CNT    = 24'd6_000_000,
  parameter logic [CNT_W-1:0]      REPEAT_CNT = 24'd3_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  button_event_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  // cnt holds (edges since entry - 1) when a deciding edge arrives.
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CNT - 1'b1;
  localparam logic [CNT_W-1:0] DBL_LAST    = DBL_CNT - 1'b1;
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CNT - 1'b1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ev_down, ev_up;
  logic             short_nx, long_nx, double_nx, repeat_nx, held_nx;

  // Simultaneous press and release pulses carry no information.
  assign ev_down = bus.pb_down & ~bus.pb_up;
  assign ev_up   = bus.pb_up & ~bus.pb_down;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    short_nx  = 1'b0;
    long_nx   = 1'b0;
    double_nx = 1'b0;
    repeat_nx = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (ev_down) state_nx = PRESS1;
      end
      PRESS1: begin
        if (ev_up) begin
          state_nx = WAIT2;
        end else if (cnt == LONG_LAST) begin
          long_nx  = 1'b1;
          state_nx = LONG;
        end
      end
      WAIT2: begin
        if (ev_down) begin
          state_nx = PRESS2;
        end else if (cnt == DBL_LAST) begin
          short_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      PRESS2: begin
        if (ev_up) begin
          double_nx = 1'b1;
          state_nx  = IDLE;
        end else if (cnt == LONG_LAST) begin
          double_nx = 1'b1;
          state_nx  = LONG;
        end
      end
      LONG: begin
        if (ev_up) begin
          state_nx = IDLE;
        end else if (cnt == REPEAT_LAST) begin
          repeat_nx = 1'b1;
          cnt_nx    = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (state_nx != state) cnt_nx = '0;
    held_nx = (state_nx == PRESS1) || (state_nx == PRESS2) || (state_nx == LONG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.short_press  <= 1'b0;
      bus.long_press   <= 1'b0;
      bus.double_press <= 1'b0;
      bus.repeat_pulse <= 1'b0;
      bus.held         <= 1'b0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      bus.short_press  <= short_nx;
      bus.long_press   <= long_nx;
      bus.double_press <= double_nx;
      bus.repeat_pulse <= repeat_nx;
      bus.held         <= held_nx;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timeouts
// (LONG_CNT=20, DBL_CNT=10, REPEAT_CNT=5).
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned fails  = 0;

  button_event_decoder_if bif();

  button_event_decoder #(
    .CNT_W      (24),
    .LONG_CNT   (24'd20),
    .DBL_CNT    (24'd10),
    .REPEAT_CNT (24'd5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {short_press, long_press, double_press, repeat_pulse, held}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bif.short_press, bif.long_press, bif.double_press, bif.repeat_pulse, bif.held};
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs for one posedge, then check outputs 1 time unit after it.
  task automatic cyc(input logic d, input logic u, input logic [4:0] exp, input string tag);
    @(negedge clk);
    bif.pb_down = d;
    bif.pb_up   = u;
    @(posedge clk);
    #1;
    bif.pb_down = 1'b0;
    bif.pb_up   = 1'b0;
    chk(tag, exp);
  endtask

  task automatic idle(input int n, input logic [4:0] exp, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, exp, tag);
  endtask

  initial begin
    bif.pb_down = 1'b0;
    bif.pb_up   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: short press
    cyc(1, 0, 5'b00001, "s1_press");
    idle(4, 5'b00001, "s1_held");
    cyc(0, 1, 5'b00000, "s1_release");
    idle(9, 5'b00000, "s1_gap");
    cyc(0, 0, 5'b10000, "s1_short");
    idle(3, 5'b00000, "s1_after");

    // 2: long press with repeats
    cyc(1, 0, 5'b00001, "s2_press");
    idle(19, 5'b00001, "s2_hold");
    cyc(0, 0, 5'b01001, "s2_long");
    for (int r = 0; r < 3; r++) begin
      idle(4, 5'b00001, "s2_between");
      cyc(0, 0, 5'b00011, "s2_repeat");
    end
    idle(1, 5'b00001, "s2_hold_tail");
    cyc(0, 1, 5'b00000, "s2_release");
    idle(12, 5'b00000, "s2_after");

    // 3: double press
    cyc(1, 0, 5'b00001, "s3_press1");
    idle(2, 5'b00001, "s3_held1");
    cyc(0, 1, 5'b00000, "s3_up1");
    idle(4, 5'b00000, "s3_gap");
    cyc(1, 0, 5'b00001, "s3_press2");
    idle(3, 5'b00001, "s3_held2");
    cyc(0, 1, 5'b00100, "s3_double");
    idle(12, 5'b00000, "s3_after");

    // 4: second press on the same edge as the WAIT2 timeout
    cyc(1, 0, 5'b00001, "s4_press1");
    idle(2, 5'b00001, "s4_held1");
    cyc(0, 1, 5'b00000, "s4_up1");
    idle(9, 5'b00000, "s4_gap");
    cyc(1, 0, 5'b00001, "s4_press2_at_timeout");
    idle(1, 5'b00001, "s4_held2");
    cyc(0, 1, 5'b00100, "s4_double");
    idle(12, 5'b00000, "s4_after");

    // 5: reset while in LONG
    cyc(1, 0, 5'b00001, "s5_press");
    idle(19, 5'b00001, "s5_hold");
    cyc(0, 0, 5'b01001, "s5_long");
    idle(3, 5'b00001, "s5_long_held");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s5_async_reset", 5'b00000);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("s5_in_reset", 5'b00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 5'b00000, "s5_up_after_reset");
    idle(25, 5'b00000, "s5_quiet");

    // 6: stray release and simultaneous pulses in IDLE, then a normal short press
    cyc(0, 1, 5'b00000, "s6_stray_up");
    cyc(1, 1, 5'b00000, "s6_both");
    idle(12, 5'b00000, "s6_quiet");
    cyc(1, 0, 5'b00001, "s6_press");
    idle(4, 5'b00001, "s6_held");
    cyc(0, 1, 5'b00000, "s6_release");
    idle(9, 5'b00000, "s6_gap");
    cyc(0, 0, 5'b10000, "s6_short");
    idle(2, 5'b00000, "s6_after");

    // 7: release on the same edge as the PRESS1 long timeout
    cyc(1, 0, 5'b00001, "s7_press");
    idle(19, 5'b00001, "s7_hold");
    cyc(0, 1, 5'b00000, "s7_up_at_timeout");
    idle(9, 5'b00000, "s7_gap");
    cyc(0, 0, 5'b10000, "s7_short");
    idle(2, 5'b00000, "s7_after");

    // 8: PRESS2 held to timeout -> double_press then LONG, release beats a repeat
    cyc(1, 0, 5'b00001, "s8_press1");
    idle(2, 5'b00001, "s8_held1");
    cyc(0, 1, 5'b00000, "s8_up1");
    idle(4, 5'b00000, "s8_gap");
    cyc(1, 0, 5'b00001, "s8_press2");
    idle(19, 5'b00001, "s8_hold2");
    cyc(0, 0, 5'b00101, "s8_double_long");
    idle(4, 5'b00001, "s8_long_held");
    cyc(0, 0, 5'b00011, "s8_repeat");
    idle(4, 5'b00001, "s8_long_held2");
    cyc(0, 1, 5'b00000, "s8_up_at_repeat");
    idle(12, 5'b00000, "s8_after");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
